// File: rtl/bbox_proj_pkg.sv
// Shared definitions for the LiDAR-box to camera-pixel projector.
// Holds the FSM encoding, the factory projection matrix and quotient sizing helpers.
// No logic lives here; everything is constants and constant functions.
package bbox_proj_pkg;

  // Projector sequencing states
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LATCH = 3'd1;
  localparam logic [2:0] ST_MAC   = 3'd2;
  localparam logic [2:0] ST_DIV   = 3'd3;
  localparam logic [2:0] ST_ACC   = 3'd4;
  localparam logic [2:0] ST_EMIT  = 3'd5;

  localparam int MAT_PARAM_W = 19;
  localparam int MAT_ELEMS   = 12;

  // Quotient carries two extra bits over the pixel width so off-image
  // results stay distinguishable from legal pixels.
  function automatic int qw_of(input int pix_w);
    return pix_w + 2;
  endfunction

  // Largest magnitude a saturated quotient may take.
  function automatic int sat_pos(input int qw);
    return (1 << (qw - 1)) - 1;
  endfunction

  // Most negative QW-bit value, used to seed the running maximum.
  function automatic int sgn_min(input int qw);
    return -(1 << (qw - 1));
  endfunction

  // Factory calibration, row-major, row*4+col.
  function automatic logic [MAT_PARAM_W-1:0] def_mat(input int idx);
    case (idx)
      0:       return 19'h0eba2;
      1:       return 19'h6e931;
      2:       return 19'h7ff84;
      3:       return 19'h7d073;
      4:       return 19'h081e0;
      5:       return 19'h00581;
      6:       return 19'h5f9da;
      7:       return 19'h7b745;
      8:       return 19'h00040;
      9:       return 19'h00000;
      10:      return 19'h00001;
      11:      return 19'h7ffef;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/bbox_projector_div.sv
// Restoring divider: signed numerator, strictly positive denominator, quotient truncated toward zero.
// Latency: exactly QW cycles after start; done pulses for one cycle with quot final.
// Backpressure: none; a new start simply restarts the division.
module proj_div
  import bbox_proj_pkg::*;
#(
  parameter int NUM_W = 37,
  parameter int QW    = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NUM_W-1:0] num,
  input  logic [NUM_W-1:0] den,
  output logic             done,
  output logic [QW-1:0]    quot
);

  localparam int DW = NUM_W + QW;
  localparam int CW = $clog2(QW);
  localparam logic [QW-1:0] Q_MAX = QW'(sat_pos(QW));

  logic [NUM_W-1:0] num_mag;
  logic [DW-1:0]    rem;
  logic [DW-1:0]    dsh;
  logic [QW-1:0]    q;
  logic [CW-1:0]    cnt;
  logic             run;
  logic             neg;
  logic             ovf;
  logic             ge;
  logic [QW-1:0]    mag;

  assign num_mag = num[NUM_W-1] ? (~num + 1'b1) : num;
  assign ge      = (rem >= dsh);

  // One quotient bit per cycle, MSB first; overflow beyond QW bits is flagged at start
  always_ff @(posedge clk) begin
    if (rst) begin
      rem  <= '0;
      dsh  <= '0;
      q    <= '0;
      cnt  <= '0;
      run  <= 1'b0;
      neg  <= 1'b0;
      ovf  <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem <= DW'(num_mag);
        dsh <= DW'(den) << (QW - 1);
        q   <= '0;
        cnt <= CW'(QW - 1);
        neg <= num[NUM_W-1];
        ovf <= (DW'(num_mag) >= (DW'(den) << QW));
        run <= 1'b1;
      end else if (run) begin
        if (ge) begin
          rem <= rem - dsh;
        end
        q   <= {q[QW-2:0], ge};
        dsh <= dsh >> 1;
        if (cnt == '0) begin
          run  <= 1'b0;
          done <= 1'b1;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

  // Saturate the magnitude, then reapply the numerator sign
  always_comb begin
    mag  = (ovf || q[QW-1]) ? Q_MAX : q;
    quot = neg ? (~mag + 1'b1) : mag;
  end

endmodule

// File: rtl/bbox_projector.sv
// Projects a 3D axis-aligned box through a loadable 3x4 matrix into a 2D pixel bbox, FWFT output FIFO.
// Latency: 2+8*(QW+2) cycles accept-to-FIFO (122 at defaults); one box in flight at a time.
// Backpressure: s_ready only in IDLE with FIFO space; m_ready pops head. Macro BBOX_PROJ_CLIP_EN enables clamping.
module bbox_projector
  import bbox_proj_pkg::*;
#(
  parameter int COORD_W    = 16,
  parameter int FRAC_IN    = 9,
  parameter int PARAM_W    = 19,
  parameter int PIX_W      = 11,
  parameter int IMG_W      = 1920,
  parameter int IMG_H      = 1080,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [3:0]         cfg_addr,
  input  logic [PARAM_W-1:0] cfg_data,
  output logic               busy,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [COORD_W-1:0] min_x,
  input  logic [COORD_W-1:0] min_y,
  input  logic [COORD_W-1:0] min_z,
  input  logic [COORD_W-1:0] max_x,
  input  logic [COORD_W-1:0] max_y,
  input  logic [COORD_W-1:0] max_z,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [PIX_W-1:0]   m_hmin,
  output logic [PIX_W-1:0]   m_hmax,
  output logic [PIX_W-1:0]   m_vmin,
  output logic [PIX_W-1:0]   m_vmax,
  output logic               m_clipped,
  output logic [15:0]        drop_cnt
);

  localparam int QW     = qw_of(PIX_W);
  localparam int CW     = $clog2(QW);
  localparam int PROD_W = COORD_W + PARAM_W;
  localparam int SUM_W  = PROD_W + 2;
  localparam int AW     = $clog2(FIFO_DEPTH);

  localparam logic signed [QW-1:0]      Q_HI   = QW'(sat_pos(QW));
  localparam logic signed [QW-1:0]      Q_LO   = QW'(sgn_min(QW));
  localparam logic signed [QW-1:0]      ONE_Q  = QW'(1);
  localparam logic signed [QW-1:0]      IMGW_Q = QW'(IMG_W);
  localparam logic signed [QW-1:0]      IMGH_Q = QW'(IMG_H);
  localparam logic signed [COORD_W-1:0] ONE_C  = COORD_W'(1 << FRAC_IN);
  localparam logic [AW:0]               FULL_C = (AW + 1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [PIX_W-1:0] hmin;
    logic [PIX_W-1:0] hmax;
    logic [PIX_W-1:0] vmin;
    logic [PIX_W-1:0] vmax;
    logic             clipped;
  } pix_box_t;

  logic [2:0]                state;
  logic [2:0]                k;
  logic [CW-1:0]             div_cnt;
  logic                      behind;
  logic [PARAM_W-1:0]        mat [MAT_ELEMS];
  logic [COORD_W-1:0]        r_min_x, r_min_y, r_min_z, r_max_x, r_max_y, r_max_z;
  logic signed [QW-1:0]      hmin, hmax, vmin, vmax;
  logic signed [COORD_W-1:0] cx, cy, cz;
  logic signed [SUM_W-1:0]   u_c, v_c, w_c;
  logic                      w_pos;
  logic                      div_start;
  logic                      du_done, dv_done;
  logic signed [QW-1:0]      qu, qv;
  logic                      out_drop;
  logic                      out_clip;
  logic signed [QW-1:0]      c_hmin, c_hmax, c_vmin, c_vmax;
  pix_box_t                  fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]             wr_ptr, rd_ptr;
  logic [AW:0]               fifo_cnt;
  logic                      fifo_wr;
  logic                      fifo_pop;

  // Sign-extend both factors so the full product is kept, then widen for the sum.
  function automatic logic signed [SUM_W-1:0] mulx(input logic signed [PARAM_W-1:0] a,
                                                   input logic signed [COORD_W-1:0] b);
    logic signed [PROD_W-1:0] p;
    p = PROD_W'(a) * PROD_W'(b);
    return SUM_W'(p);
  endfunction

`ifdef BBOX_PROJ_CLIP_EN
  function automatic logic signed [QW-1:0] clampq(input logic signed [QW-1:0] v,
                                                  input logic signed [QW-1:0] hi);
    if (v < ONE_Q) return ONE_Q;
    if (v > hi)    return hi;
    return v;
  endfunction
`endif

  assign busy      = (state != ST_IDLE);
  assign s_ready   = !rst && (state == ST_IDLE) && (fifo_cnt != FULL_C);
  assign m_valid   = (fifo_cnt != '0);
  assign fifo_pop  = m_valid && m_ready;
  assign fifo_wr   = (state == ST_EMIT) && !out_drop;

  // Corner k picks max or min per axis from its bits (x=k[2], y=k[1], z=k[0])
  always_comb begin
    cx = k[2] ? r_max_x : r_min_x;
    cy = k[1] ? r_max_y : r_min_y;
    cz = k[0] ? r_max_z : r_min_z;
    u_c = mulx(mat[0], cx) + mulx(mat[1], cy) + mulx(mat[2],  cz) + mulx(mat[3],  ONE_C);
    v_c = mulx(mat[4], cx) + mulx(mat[5], cy) + mulx(mat[6],  cz) + mulx(mat[7],  ONE_C);
    w_c = mulx(mat[8], cx) + mulx(mat[9], cy) + mulx(mat[10], cz) + mulx(mat[11], ONE_C);
  end

  assign w_pos     = !w_c[SUM_W-1] && (w_c != '0);
  assign div_start = (state == ST_MAC) && w_pos;

  proj_div #(.NUM_W(SUM_W), .QW(QW)) u_div_u (
    .clk   (clk),
    .rst   (rst),
    .start (div_start),
    .num   (u_c),
    .den   (w_c),
    .done  (du_done),
    .quot  (qu)
  );

  proj_div #(.NUM_W(SUM_W), .QW(QW)) u_div_v (
    .clk   (clk),
    .rst   (rst),
    .start (div_start),
    .num   (v_c),
    .den   (w_c),
    .done  (dv_done),
    .quot  (qv)
  );

  // Matrix: factory values on reset, writes only while idle and to a real element
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MAT_ELEMS; i++) begin
        mat[i] <= PARAM_W'(def_mat(i));
      end
    end else if (cfg_we && !busy && (cfg_addr < 4'd12)) begin
      mat[cfg_addr] <= cfg_data;
    end
  end

  // Sequencer: latch box, then per corner MAC -> DIV -> ACC, finally EMIT
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      k       <= '0;
      div_cnt <= '0;
      behind  <= 1'b0;
      hmin    <= Q_HI;
      hmax    <= Q_LO;
      vmin    <= Q_HI;
      vmax    <= Q_LO;
      r_min_x <= '0;
      r_min_y <= '0;
      r_min_z <= '0;
      r_max_x <= '0;
      r_max_y <= '0;
      r_max_z <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (s_valid && s_ready) begin
            r_min_x <= min_x;
            r_min_y <= min_y;
            r_min_z <= min_z;
            r_max_x <= max_x;
            r_max_y <= max_y;
            r_max_z <= max_z;
            state   <= ST_LATCH;
          end
        end
        ST_LATCH: begin
          hmin   <= Q_HI;
          hmax   <= Q_LO;
          vmin   <= Q_HI;
          vmax   <= Q_LO;
          behind <= 1'b0;
          k      <= '0;
          state  <= ST_MAC;
        end
        ST_MAC: begin
          if (w_pos) begin
            div_cnt <= CW'(QW - 1);
            state   <= ST_DIV;
          end else begin
            // Corner behind the camera: box is doomed, no point dividing
            behind <= 1'b1;
            state  <= ST_ACC;
          end
        end
        ST_DIV: begin
          if (div_cnt == '0) begin
            state <= ST_ACC;
          end else begin
            div_cnt <= div_cnt - 1'b1;
          end
        end
        ST_ACC: begin
          // done pulses only when this corner actually went through the dividers
          if (du_done && dv_done) begin
            if (qu < hmin) hmin <= qu;
            if (qu > hmax) hmax <= qu;
            if (qv < vmin) vmin <= qv;
            if (qv > vmax) vmax <= qv;
          end
          if (k == 3'd7) begin
            state <= ST_EMIT;
          end else begin
            k     <= k + 1'b1;
            state <= ST_MAC;
          end
        end
        ST_EMIT: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Accept / reject the finished bbox and form the FIFO entry
  always_comb begin
`ifdef BBOX_PROJ_CLIP_EN
    out_drop = behind || (hmax < ONE_Q) || (hmin > IMGW_Q) ||
               (vmax < ONE_Q) || (vmin > IMGH_Q);
    c_hmin   = clampq(hmin, IMGW_Q);
    c_hmax   = clampq(hmax, IMGW_Q);
    c_vmin   = clampq(vmin, IMGH_Q);
    c_vmax   = clampq(vmax, IMGH_Q);
    out_clip = (c_hmin != hmin) || (c_hmax != hmax) ||
               (c_vmin != vmin) || (c_vmax != vmax);
`else
    out_drop = behind || (hmin < ONE_Q) || (vmin < ONE_Q) ||
               (hmax > IMGW_Q) || (vmax > IMGH_Q);
    c_hmin   = hmin;
    c_hmax   = hmax;
    c_vmin   = vmin;
    c_vmax   = vmax;
    out_clip = 1'b0;
`endif
  end

  // Rejected boxes are counted, saturating
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if ((state == ST_EMIT) && out_drop && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

  // FIFO storage; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      fifo_mem[wr_ptr] <= '{hmin:    PIX_W'(c_hmin),
                            hmax:    PIX_W'(c_hmax),
                            vmin:    PIX_W'(c_vmin),
                            vmax:    PIX_W'(c_vmax),
                            clipped: out_clip};
    end
  end

  // FIFO pointers and occupancy; simultaneous write and pop both take effect
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (fifo_wr)  wr_ptr <= wr_ptr + 1'b1;
      if (fifo_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({fifo_wr, fifo_pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  assign m_hmin    = fifo_mem[rd_ptr].hmin;
  assign m_hmax    = fifo_mem[rd_ptr].hmax;
  assign m_vmin    = fifo_mem[rd_ptr].vmin;
  assign m_vmax    = fifo_mem[rd_ptr].vmax;
  assign m_clipped = fifo_mem[rd_ptr].clipped;

endmodule

// File: tb/tb_bbox_projector.sv
// Directed bench for bbox_projector with a queue scoreboard and independent output monitor.
// Expected pixel boxes are hand-derived from the loaded matrix and box extents.
// Honours BBOX_PROJ_CLIP_EN for the partially off-image case.
module tb_bbox_projector;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [18:0] cfg_data;
  logic        busy;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] min_x, min_y, min_z, max_x, max_y, max_z;
  logic        m_valid;
  logic        m_ready;
  logic [10:0] m_hmin, m_hmax, m_vmin, m_vmax;
  logic        m_clipped;
  logic [15:0] drop_cnt;

  always #5 clk = ~clk;

  bbox_projector dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .busy      (busy),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .min_x     (min_x),
    .min_y     (min_y),
    .min_z     (min_z),
    .max_x     (max_x),
    .max_y     (max_y),
    .max_z     (max_z),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_hmin    (m_hmin),
    .m_hmax    (m_hmax),
    .m_vmin    (m_vmin),
    .m_vmax    (m_vmax),
    .m_clipped (m_clipped),
    .drop_cnt  (drop_cnt)
  );

  typedef struct packed {
    logic [10:0] hmin;
    logic [10:0] hmax;
    logic [10:0] vmin;
    logic [10:0] vmax;
    logic        clipped;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   exp_drop = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic exp_t mk(input int h0, input int h1, input int v0, input int v1, input bit c);
    exp_t e;
    e.hmin = 11'(h0);
    e.hmax = 11'(h1);
    e.vmin = 11'(v0);
    e.vmax = 11'(v1);
    e.clipped = c;
    return e;
  endfunction

  // Monitor: every head actually popped is checked against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && m_valid && m_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", m_valid, 0);
        end else begin
          e = sb.pop_front();
          chk("hmin", m_hmin, e.hmin);
          chk("hmax", m_hmax, e.hmax);
          chk("vmin", m_vmin, e.vmin);
          chk("vmax", m_vmax, e.vmax);
          chk("clipped", m_clipped, e.clipped);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int addr, input int val);
    cfg_we   = 1'b1;
    cfg_addr = 4'(addr);
    cfg_data = 19'(val);
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic load_test_matrix();
    int vals[12] = '{6400, 0, 61440, 0, 0, 6400, 34560, 0, 0, 0, 64, 0};
    for (int i = 0; i < 12; i++) cfg_write(i, vals[i]);
  endtask

  task automatic send_box(input int x0, input int x1, input int y0, input int y1,
                          input int z0, input int z1);
    bit ok;
    ok = 1'b0;
    min_x = 16'(x0); max_x = 16'(x1);
    min_y = 16'(y0); max_y = 16'(y1);
    min_z = 16'(z0); max_z = 16'(z1);
    s_valid = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if (s_ready) begin
        ok = 1'b1;
        tick();
        break;
      end
      tick();
    end
    s_valid = 1'b0;
    if (!ok) chk("accept_timeout", s_ready, 1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) chk("idle_timeout", busy, 0);
  endtask

  initial begin
    int lat;
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    s_valid = 1'b0; m_ready = 1'b1;
    min_x = '0; min_y = '0; min_z = '0; max_x = '0; max_y = '0; max_z = '0;
    tick(); tick();
    chk("s_ready_in_reset", s_ready, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("reset_m_valid", m_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_drop_cnt", drop_cnt, 0);
    chk("reset_s_ready", s_ready, 1);

    // Factory matrix, point at x=10 m: u/w=948, v/w=503
    sb.push_back(mk(948, 948, 503, 503, 0));
    send_box(5120, 5120, 0, 0, 0, 0);
    wait_idle();
    chk("default_drop_cnt", drop_cnt, 0);

    // Pinhole test matrix: f=100, cx=960, cy=540; box +/-1 m at z=10 m
    load_test_matrix();
    sb.push_back(mk(950, 970, 530, 550, 0));
    send_box(-512, 512, -512, 512, 5120, 5120);
    lat = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      lat++;
      if (m_valid) break;
    end
    chk("latency", lat, 122);
    wait_idle();

    // cx=0 puts the box across the left image edge
    cfg_write(2, 0);
`ifdef BBOX_PROJ_CLIP_EN
    sb.push_back(mk(1, 10, 530, 550, 1));
`else
    exp_drop++;
`endif
    send_box(-512, 512, -512, 512, 5120, 5120);
    wait_idle();
    chk("edge_drop_cnt", drop_cnt, exp_drop);
    cfg_write(2, 61440);

    // Box reaching behind the camera
    exp_drop++;
    send_box(-512, 512, -512, 512, -512, 5120);
    wait_idle();
    tick(); tick();
    chk("behind_drop_cnt", drop_cnt, exp_drop);
    chk("behind_no_output", m_valid, 0);

    // Fill FIFO with consumer stalled; centres x=0..3 m give hmin 950..980
    m_ready = 1'b0;
    for (int m = 0; m < 4; m++) begin
      sb.push_back(mk(950 + 10 * m, 970 + 10 * m, 530, 550, 0));
      send_box(512 * m - 512, 512 * m + 512, -512, 512, 5120, 5120);
      wait_idle();
    end
    chk("full_s_ready", s_ready, 0);
    for (int i = 0; i < 5; i++) tick();
    chk("full_s_ready_hold", s_ready, 0);
    chk("full_m_valid", m_valid, 1);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("s_ready_after_pop", s_ready, 1);
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk("drained_m_valid", m_valid, 0);

    // Config writes while busy are ignored for this box and the next
    sb.push_back(mk(950, 970, 530, 550, 0));
    send_box(-512, 512, -512, 512, 5120, 5120);
    chk("busy_during_cfg", busy, 1);
    cfg_write(2, 0);
    wait_idle();
    sb.push_back(mk(950, 970, 530, 550, 0));
    send_box(-512, 512, -512, 512, 5120, 5120);
    wait_idle();
    for (int i = 0; i < 4; i++) tick();

    // Reset mid-flight: box abandoned, counters and matrix back to defaults
    send_box(-512, 512, -512, 512, 5120, 5120);
    for (int i = 0; i < 50; i++) tick();
    rst = 1'b1;
    tick(); tick();
    chk("midrst_m_valid", m_valid, 0);
    chk("midrst_drop_cnt", drop_cnt, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_s_ready", s_ready, 0);
    rst = 1'b0;
    exp_drop = 0;
    tick();
    sb.push_back(mk(948, 948, 503, 503, 0));
    send_box(5120, 5120, 0, 0, 0, 0);
    wait_idle();
    for (int i = 0; i < 4; i++) tick();
    chk("post_rst_drop_cnt", drop_cnt, exp_drop);
    chk("scoreboard_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bbox_projector.md
Name: bbox_projector

Overview:
- Projects a 3D axis-aligned LiDAR cluster box into the camera image plane and emits a 2D pixel bbox.
- Processing: generate the 8 box corners, multiply each by a runtime-loadable 3x4 projection matrix, divide u/w and v/w, then track the min/max pixel per axis.
- Then bounds-checks against a parametrised image size and queues the result in an output FIFO.
- Sits between the cluster/bbox extractor and the camera-overlay/AXI output stage.

Parameters:
- COORD_W, 16, input coordinate width, signed, FRAC_IN fractional bits
- FRAC_IN, 9, fractional bits of coordinates (metres)
- PARAM_W, 19, matrix element width, signed, 6 fractional bits
- PIX_W, 11, output pixel coordinate width, unsigned
- IMG_W, 1920, image width in pixels; valid columns 1..IMG_W
- IMG_H, 1080, image height in pixels; valid rows 1..IMG_H
- FIFO_DEPTH, 4, output FIFO entries (power of two, >=2)

Ports:
- clk, in, 1, clock
- rst, in, 1, synchronous active-high reset
- cfg_we, in, 1, matrix element write strobe
- cfg_addr, in, 4, element index row*4+col (0..11; 12..15 ignored)
- cfg_data, in, PARAM_W, element value
- busy, out, 1, box in processing
- s_valid, in, 1, input box valid
- s_ready, out, 1, block accepts box
- min_x/min_y/min_z/max_x/max_y/max_z, in, COORD_W each, box extents
- m_valid, out, 1, FIFO head valid
- m_ready, in, 1, consumer pops head
- m_hmin/m_hmax/m_vmin/m_vmax, out, PIX_W each, pixel bbox
- m_clipped, out, 1, bbox was clamped to image
- drop_cnt, out, 16, saturating count of rejected boxes

Behaviour:
- Reset: state IDLE, FIFO emptied, m_valid=0, busy=0, drop_cnt=0, matrix loaded with package defaults. s_ready=0 while rst is high. A box in flight is abandoned with no output and no drop count.
- s_ready = (state==IDLE) & (FIFO count < FIFO_DEPTH). A box is accepted on s_valid&s_ready and its extents are latched. Admission guarantees the FIFO never overflows.
- cfg_we is honoured only when busy=0 and cfg_addr<12; otherwise it is ignored.
- FSM states:
  - IDLE
  - LATCH (1 cycle): init min regs to the max signed value, max regs to the min signed value; corner index k=0.
  - MAC (1 cycle): u,v,w = row dot [x,y,z,1.0], where 1.0 = 1<<FRAC_IN. Corner k uses x=k[2]?max:min, y=k[1]?max:min, z=k[0]?max:min. Products are COORD_W+PARAM_W bits; sums +2 bits, no truncation.
  - DIV (QW=PIX_W+2 cycles): two proj_div instances compute u/w and v/w in parallel.
  - ACC (1 cycle): update min/max; if k==7 go to EMIT, else k+1 and back to MAC.
  - EMIT (1 cycle): write or drop, then return to IDLE.
- Latency from accept to FIFO write: 2+8*(QW+2) cycles; 122 cycles with defaults. busy=1 in every state except IDLE.
- Division: quotient truncates toward zero; signed QW-bit result saturated to +/-(2^(QW-1)-1).
- If w<=0 for any corner (behind camera), the box is dropped, skipping the divide for that corner.
- Drop condition without clip: hmin<1 | vmin<1 | hmax>IMG_W | vmax>IMG_H. A drop increments drop_cnt (saturates at 0xFFFF) and writes nothing to the FIFO.
- FIFO is first-word fall-through: m_valid = not empty, outputs show the head, pop on m_valid&m_ready, strict order.
- A pop and an EMIT write in the same cycle are both honoured.

Optional Feature:
- Macro BBOX_PROJ_CLIP_EN.
- Defined: drop only if the box is fully outside (hmax<1 | hmin>IMG_W | vmax<1 | vmin>IMG_H) or behind the camera. Otherwise clamp each coordinate to 1..IMG_W or 1..IMG_H; m_clipped=1 if any value changed.
- Undefined: the drop rule above applies; m_clipped is tied to 0.

Decomposition:
- Package bbox_proj_pkg holds:
  - FSM state encoding
  - default matrix constants (row0 0x0eba2,0x6e931,0x7ff84,0x7d073; row1 0x081e0,0x00581,0x5f9da,0x7b745; row2 0x00040,0x00000,0x00001,0x7ffef)
  - QW derivation, saturation limits
- Sub-module proj_div: sequential restoring signed/positive-divisor divider.
  - Interface: start, done, num, den, quot.
  - Fixed QW-cycle latency; saturates the quotient.

Test Plan:
- Load row0=[6400,0,61440,0], row1=[0,6400,34560,0], row2=[0,0,64,0]. Box x,y in [-1,1], z=10 -> after 122 cycles the FIFO shows hmin=950, hmax=970, vmin=530, vmax=550, clipped=0.
- Same matrix with cx=0 (row0[2]=0) -> clip undefined: dropped, drop_cnt=1. Clip defined: emitted hmin=1, hmax=10, clipped=1.
- min_z=-1 -> box dropped in both modes, drop_cnt increments, no FIFO write.
- m_ready=0, send 4 boxes -> s_ready stays 0 after the 4th EMIT. Pulse m_ready once -> s_ready rises next cycle; outputs emerge in send order.
- rst asserted 50 cycles after accept -> m_valid=0, drop_cnt=0, default matrix restored, next box processed normally.
- cfg_we while busy=1 -> matrix unchanged; the current and next box use the old values.
